// File: rtl/cu_pkg.sv
// cu_pkg: state and instruction-class types, opcode/ALU/condition constants
// and the opcode decoder shared by the multicycle control unit.
package cu_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEMRD, S_MEMWR, S_WB} state_e;
  typedef enum logic [2:0] {CL_NONE, CL_MOV, CL_ADD, CL_SUB, CL_CMP, CL_LDR, CL_STR, CL_BR} class_e;
  localparam logic [11:0] OP_MOV_R = 12'he1a;
  localparam logic [11:0] OP_MOV_I = 12'he3a;
  localparam logic [11:0] OP_ADD_R = 12'he08;
  localparam logic [11:0] OP_ADD_I = 12'he28;
  localparam logic [11:0] OP_SUB_R = 12'he04;
  localparam logic [11:0] OP_SUB_I = 12'he24;
  localparam logic [11:0] OP_CMP_R = 12'he15;
  localparam logic [11:0] OP_CMP_I = 12'he35;
  localparam logic [11:0] OP_LDR = 12'he59;
  localparam logic [11:0] OP_STR = 12'he58;
  localparam logic [3:0] CLASS_BR = 4'ha;
  localparam logic [2:0] ALU_MOV = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_GE = 4'ha;
  localparam logic [3:0] COND_LT = 4'hb;
  localparam logic [3:0] COND_GT = 4'hc;
  localparam logic [3:0] COND_LE = 4'hd;
  localparam logic [3:0] COND_AL = 4'he;
  // Exact encodings take priority over the branch class nibble.
  function automatic class_e decode_class(input logic [11:0] op);
    return (op == OP_MOV_R || op == OP_MOV_I) ? CL_MOV :
           (op == OP_ADD_R || op == OP_ADD_I) ? CL_ADD :
           (op == OP_SUB_R || op == OP_SUB_I) ? CL_SUB :
           (op == OP_CMP_R || op == OP_CMP_I) ? CL_CMP :
           (op == OP_LDR) ? CL_LDR :
           (op == OP_STR) ? CL_STR :
           (op[7:4] == CLASS_BR) ? CL_BR : CL_NONE;
  endfunction
  function automatic logic [2:0] alu_ctrl(input class_e c);
    return (c == CL_MOV) ? ALU_MOV : (c inside {CL_SUB, CL_CMP, CL_BR}) ? ALU_SUB : ALU_ADD;
  endfunction
endpackage

// File: rtl/multicycle_control_unit_cond_check.sv
// cond_check: evaluates a branch condition code against the {N,Z,C,V} flags.
module cond_check
  import cu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);
  logic n, z, c_unused, v;
  assign {n, z, c_unused, v} = flags;
  always_comb begin
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_GE: taken = n == v;
      COND_LT: taken = n != v;
      COND_GT: taken = !z && n == v;
      COND_LE: taken = z || n != v;
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore control FSM for a multicycle datapath with
// bounded memory waits, branch condition evaluation and error pulses.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W  = 12,
  parameter int ALUCTRL_W = 3,
  parameter int WAIT_MAX  = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [3:0]           alu_flags,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCSrc,
  output logic                 MemWrite,
  output logic                 MemToReg,
  output logic                 RegWrite,
  output logic                 ALUSrc,
  output logic                 RegDst,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 busy,
  output logic                 illegal,
  output logic                 mem_timeout
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  state_e         state_q;
  class_e         class_q, dec;
  logic [3:0]     cond_q, flags_q;
  logic           imm_q, en_q, illegal_q, timeout_q;
  logic [WW-1:0]  wait_q;
  logic           taken, mem_st, wait_hit, br_taken;
  assign dec = decode_class(opcode[11:0]);
  // en_q keeps FETCH idle for the first cycle after reset so no request issues.
  assign mem_st = (state_q == S_FETCH && en_q) || state_q == S_MEMRD || state_q == S_MEMWR;
  assign wait_hit = mem_st && !mem_ready && wait_q == WW'(WAIT_MAX - 1);
  assign br_taken = state_q == S_EXEC && class_q == CL_BR && taken;
  cond_check u_cond (
    .cond  (cond_q),
    .flags (flags_q),
    .taken (taken)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      class_q   <= CL_NONE;
      cond_q    <= '0;
      imm_q     <= 1'b0;
      flags_q   <= '0;
      wait_q    <= '0;
      en_q      <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      en_q      <= 1'b1;
      illegal_q <= 1'b0;
      timeout_q <= wait_hit;
      wait_q    <= (mem_st && !mem_ready && !wait_hit) ? wait_q + 1'b1 : '0;
      case (state_q)
        S_FETCH: state_q <= (en_q && mem_ready) ? S_DECODE : S_FETCH;
        S_DECODE: begin
          class_q   <= dec;
          cond_q    <= opcode[11:8];
          imm_q     <= opcode[5];
          illegal_q <= dec == CL_NONE;
          state_q   <= (dec == CL_NONE) ? S_FETCH : S_EXEC;
        end
        S_EXEC: begin
          if (class_q == CL_CMP) flags_q <= alu_flags;
          state_q <= (class_q == CL_LDR) ? S_MEMRD :
                     (class_q == CL_STR) ? S_MEMWR :
                     (class_q inside {CL_MOV, CL_ADD, CL_SUB}) ? S_WB : S_FETCH;
        end
        S_MEMRD: state_q <= mem_ready ? S_WB : wait_hit ? S_FETCH : S_MEMRD;
        S_MEMWR: state_q <= (mem_ready || wait_hit) ? S_FETCH : S_MEMWR;
        default: state_q <= S_FETCH;
      endcase
    end
  end
  assign mem_req     = mem_st;
  assign AdrSrc      = state_q == S_MEMRD || state_q == S_MEMWR;
  assign IRWrite     = state_q == S_FETCH && en_q && mem_ready;
  assign PCWrite     = IRWrite || br_taken;
  assign PCSrc       = br_taken;
  assign MemWrite    = state_q == S_MEMWR;
  assign MemToReg    = state_q == S_WB && class_q == CL_LDR;
  assign RegWrite    = state_q == S_WB;
  assign RegDst      = state_q == S_WB && imm_q;
  assign ALUSrc      = state_q == S_EXEC && class_q != CL_MOV;
  assign ALUControl  = (state_q == S_EXEC) ? ALUCTRL_W'(alu_ctrl(class_q)) : '0;
  assign busy        = state_q != S_FETCH;
  assign illegal     = illegal_q;
  assign mem_timeout = timeout_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed per-cycle scoreboard bench for the control unit.
module tb_multicycle_control_unit;
  localparam int WAIT_MAX = 15;
  localparam logic [15:0] REQ = 16'h8000, ADR = 16'h4000, IRW = 16'h2000, PCW = 16'h1000;
  localparam logic [15:0] PCS = 16'h0800, MW = 16'h0400, M2R = 16'h0200, RW = 16'h0100;
  localparam logic [15:0] ASRC = 16'h0080, RDST = 16'h0040, BUSY = 16'h0004, ILL = 16'h0002, TO = 16'h0001;
  localparam logic [15:0] FET = REQ | IRW | PCW;
  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;
  sb_t sb[$];
  logic clk = 1'b0, rst_n, rdy;
  logic [11:0] op;
  logic [3:0] fl;
  logic mem_req, adr_src, ir_write, pc_write, pc_src, mem_write, mem_to_reg, reg_write, alu_src, reg_dst;
  logic [2:0] alu_control;
  logic busy, illegal, mem_timeout;
  logic [15:0] obs;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  multicycle_control_unit #(.OPCODE_W(12), .ALUCTRL_W(3), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(op), .alu_flags(fl), .mem_ready(rdy),
    .mem_req(mem_req), .AdrSrc(adr_src), .IRWrite(ir_write), .PCWrite(pc_write), .PCSrc(pc_src),
    .MemWrite(mem_write), .MemToReg(mem_to_reg), .RegWrite(reg_write), .ALUSrc(alu_src), .RegDst(reg_dst),
    .ALUControl(alu_control), .busy(busy), .illegal(illegal), .mem_timeout(mem_timeout)
  );
  assign obs = {mem_req, adr_src, ir_write, pc_write, pc_src, mem_write, mem_to_reg, reg_write,
                alu_src, reg_dst, alu_control, busy, illegal, mem_timeout};
  function automatic logic [15:0] alu(input logic [2:0] v);
    return {10'b0, v, 3'b0};
  endfunction
  task automatic cyc(input string tag, input logic [15:0] exp);
    sb_t e;
    sb.push_back('{tag, exp});
    @(negedge clk);
    e = sb.pop_front();
    compared++;
    assert (obs === e.exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; rdy = 1'b0; op = 12'h000; fl = 4'h0;
    @(posedge clk);
    #1;
    cyc("rst_a", 16'h0);
    cyc("rst_b", 16'h0);
    rst_n = 1'b1; rdy = 1'b1; op = 12'he28;
    cyc("post_rst", 16'h0);
    cyc("add_f", FET);
    cyc("add_d", BUSY);
    cyc("add_e", ASRC | alu(3'b010) | BUSY);
    cyc("add_wb", RW | RDST | BUSY);
    op = 12'he35; fl = 4'b0100;
    cyc("cmp_f", FET);
    cyc("cmp_d", BUSY);
    cyc("cmp_e", ASRC | alu(3'b110) | BUSY);
    op = 12'h0a0; fl = 4'b0000;
    cyc("beq_f", FET);
    cyc("beq_d", BUSY);
    cyc("beq_taken", ASRC | alu(3'b110) | PCW | PCS | BUSY);
    op = 12'he35;
    cyc("cmp2_f", FET);
    cyc("cmp2_d", BUSY);
    cyc("cmp2_e", ASRC | alu(3'b110) | BUSY);
    op = 12'h0a0; fl = 4'b0100;
    cyc("beq2_f", FET);
    cyc("beq2_d", BUSY);
    cyc("beq_not", ASRC | alu(3'b110) | BUSY);
    op = 12'h1a0;
    cyc("bne_f", FET);
    cyc("bne_d", BUSY);
    cyc("bne_taken", ASRC | alu(3'b110) | PCW | PCS | BUSY);
    op = 12'hfa0;
    cyc("bnv_f", FET);
    cyc("bnv_d", BUSY);
    cyc("bnv_not", ASRC | alu(3'b110) | BUSY);
    op = 12'he3a;
    cyc("mov_f", FET);
    cyc("mov_d", BUSY);
    cyc("mov_e", alu(3'b000) | BUSY);
    cyc("mov_wb", RW | RDST | BUSY);
    op = 12'he04;
    cyc("sub_f", FET);
    cyc("sub_d", BUSY);
    cyc("sub_e", ASRC | alu(3'b110) | BUSY);
    cyc("sub_wb", RW | BUSY);
    op = 12'he59;
    cyc("ldr_f", FET);
    cyc("ldr_d", BUSY);
    cyc("ldr_e", ASRC | alu(3'b010) | BUSY);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ldr_wait", REQ | ADR | BUSY);
    rdy = 1'b1;
    cyc("ldr_done", REQ | ADR | BUSY);
    cyc("ldr_wb", M2R | RW | BUSY);
    cyc("ldr2_f", FET);
    cyc("ldr2_d", BUSY);
    cyc("ldr2_e", ASRC | alu(3'b010) | BUSY);
    rdy = 1'b0;
    for (int i = 0; i < WAIT_MAX - 1; i++) cyc("ldr2_wait", REQ | ADR | BUSY);
    rdy = 1'b1;
    cyc("ldr2_edge_done", REQ | ADR | BUSY);
    cyc("ldr2_wb", M2R | RW | BUSY);
    op = 12'he58;
    cyc("str_f_no_to", FET);
    cyc("str_d", BUSY);
    cyc("str_e", ASRC | alu(3'b010) | BUSY);
    rdy = 1'b0;
    for (int i = 0; i < WAIT_MAX; i++) cyc("str_wait", REQ | ADR | MW | BUSY);
    cyc("str_timeout", REQ | TO);
    rdy = 1'b1; op = 12'hfff;
    cyc("ill_f", FET);
    cyc("ill_d", BUSY);
    rdy = 1'b0;
    cyc("ill_pulse", REQ | ILL);
    cyc("ill_once", REQ);
    rdy = 1'b1; op = 12'he35; fl = 4'b0100;
    cyc("cmp3_f", FET);
    cyc("cmp3_d", BUSY);
    cyc("cmp3_e", ASRC | alu(3'b110) | BUSY);
    op = 12'he58;
    cyc("str2_f", FET);
    cyc("str2_d", BUSY);
    cyc("str2_e", ASRC | alu(3'b010) | BUSY);
    rdy = 1'b0;
    cyc("str2_wait1", REQ | ADR | MW | BUSY);
    cyc("str2_wait2", REQ | ADR | MW | BUSY);
    rst_n = 1'b0;
    cyc("str2_in_rst", REQ | ADR | MW | BUSY);
    rst_n = 1'b1; rdy = 1'b1; op = 12'h0a0;
    cyc("rst_memwr", 16'h0);
    cyc("beq3_f", FET);
    cyc("beq3_d", BUSY);
    cyc("beq3_flags_clr", ASRC | alu(3'b110) | BUSY);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter OPCODE_W, default 12, instruction opcode field width.
REQ-002 SHALL have parameter ALUCTRL_W, default 3, ALU control width.
REQ-003 SHALL have parameter WAIT_MAX, default 15, maximum memory wait cycles before abort.
REQ-004 SHALL use one clock and a synchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 opcode  in  OPCODE_W  instruction bits [31:20]; [11:8] cond, [7:4] class.
REQ-008 alu_flags  in  4  {N,Z,C,V} from ALU, current cycle.
REQ-009 mem_ready  in  1  memory completes the current request this cycle.
REQ-010 mem_req  out  1  memory request active.
REQ-011 AdrSrc  out  1  0 = PC address, 1 = ALU result address.
REQ-012 IRWrite, PCWrite, PCSrc  out  1 each  latch instruction / update PC / 1 selects branch target.
REQ-013 MemWrite, MemToReg, RegWrite, ALUSrc, RegDst  out  1 each  datapath strobes and selects.
REQ-014 ALUControl  out  ALUCTRL_W  ALU operation.
REQ-015 busy  out  1  high in every state except FETCH.
REQ-016 illegal, mem_timeout  out  1 each  one-cycle error pulses.

Function
REQ-017 FSM states: FETCH, DECODE, EXEC, MEMRD, MEMWR, WB.
REQ-018 FETCH: mem_req=1, AdrSrc=0; hold until mem_ready; on mem_ready, IRWrite=1 and PCWrite=1 (PCSrc=0) for that cycle, then DECODE.
REQ-019 DECODE: one cycle; registers the instruction class from opcode; unmatched opcode with opcode[7:4]!=4'hA pulses illegal and returns to FETCH.
REQ-020 Decode table: e1a/e3a MOV ALU 000; e08/e28 ADD 010; e04/e24 SUB 110; e15/e35 CMP 110; e59 LDR 010; e58 STR 010; opcode[7:4]==A branch 110; bit 5 of opcode (immediate form) drives RegDst=1; ALUSrc=1 for all except MOV.
REQ-021 EXEC, MOV/ADD/SUB: ALUControl per table, then WB.
REQ-022 EXEC, CMP: latch alu_flags into internal flag register at end of the cycle, no RegWrite, then FETCH.
REQ-023 EXEC, LDR -> MEMRD; STR -> MEMWR; both with AdrSrc=1 in the following state.
REQ-024 EXEC, branch: evaluate cond against flag register; taken -> PCWrite=1, PCSrc=1 this cycle; either way then FETCH.
REQ-025 Cond codes: 0 EQ(Z), 1 NE(!Z), A GE(N==V), B LT(N!=V), C GT(!Z&&N==V), D LE(Z||N!=V), E AL; others never taken.
REQ-026 MEMRD: mem_req=1 until mem_ready, then WB with MemToReg=1.
REQ-027 MEMWR: mem_req=1, MemWrite=1 until mem_ready, then FETCH.
REQ-028 WB: RegWrite=1 for exactly one cycle, then FETCH.
REQ-029 Wait counter counts cycles in FETCH/MEMRD/MEMWR with mem_ready low, cleared on state entry; reaching WAIT_MAX pulses mem_timeout, suppresses all write strobes, returns to FETCH.
REQ-030 mem_ready in the same cycle the counter reaches WAIT_MAX: completion wins, no timeout.
REQ-031 Minimum latencies with mem_ready=1: MOV/ADD/SUB 4 cycles, LDR 5, STR 4, CMP 3, branch 3.
REQ-032 All strobes are decoded from the registered state only (Moore), except FETCH/MEM completion strobes, which are gated by mem_ready.

Reset
REQ-033 rst_n low at a rising edge SHALL force state FETCH, flags 0000, wait counter 0, decoded class cleared.
REQ-034 During and one cycle after reset, all strobes, mem_req, illegal, mem_timeout SHALL be 0; reset mid-MEMWR SHALL drop MemWrite at that edge.

Structure
REQ-035 Package cu_pkg SHALL hold the state enum, instruction-class enum, opcode constants, ALU control constants and cond code constants.
REQ-036 Combinational sub-module cond_check (cond, flags -> taken) SHALL implement REQ-025.

Verification
REQ-037 ADD imm e28, mem_ready=1 always -> IRWrite cycle 1, ALUControl=010 cycle 3, RegWrite=1, RegDst=1 in cycle 4 only.
REQ-038 CMP e35 with alu_flags=0100, then BEQ (opcode 0Axx) -> PCWrite=1, PCSrc=1 in branch EXEC; repeat with flags 0000 -> no PCWrite.
REQ-039 LDR e59, mem_ready low 3 cycles in MEMRD -> mem_req held 4 cycles, MemToReg=1 and RegWrite=1 in WB, total 8 cycles.
REQ-040 STR e58, mem_ready never asserted -> MemWrite high WAIT_MAX cycles, mem_timeout pulse 1 cycle, FSM in FETCH, no RegWrite.
REQ-041 opcode fff -> illegal pulses once after DECODE, return to FETCH, no writes.
REQ-042 rst_n low mid-MEMWR -> next cycle state FETCH, MemWrite=0, flags 0000.
